// File: rtl/rpc_match_referee.sv
// rpc_match_referee
// Sequential best-of-N rock-paper-scissors referee. Accepts one pair of
// one-hot moves per handshake, judges the round, keeps per-player scores and
// declares the match winner once either player reaches ROUNDS_TO_WIN.
//
// Optional feature macro: RPC_INVALID_FORFEIT_EN
//   defined   : a round where exactly one move is illegal goes to the other
//               player; both illegal is still res_invalid.
//   undefined : any illegal move yields res_invalid with no score change.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   start               pulse: clear scores and (re)start a match
//   in_valid/in_ready   move pair handshake
//   inA, inB            one-hot moves: bit0 rock, bit1 paper, bit2 scissors
//   res_valid           one-cycle pulse qualifying res_tie/winA/winB/invalid
//   scoreA, scoreB      round wins in the current match
//   match_done          match decided, held until next start
//   match_winner        0 = A, 1 = B (meaningful while match_done=1)
//
// state | meaning
// IDLE  | after reset, waiting for start, nothing accepted
// PLAY  | match running, one move pair accepted per cycle
// DONE  | match decided, scores/winner held until start
module rpc_match_referee #(
  parameter int ROUNDS_TO_WIN = 3,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       inA,
  input  logic [2:0]       inB,
  output logic             res_valid,
  output logic             res_tie,
  output logic             res_winA,
  output logic             res_winB,
  output logic             res_invalid,
  output logic [CNT_W-1:0] scoreA,
  output logic [CNT_W-1:0] scoreB,
  output logic             match_done,
  output logic             match_winner
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(ROUNDS_TO_WIN);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [1:0]       state;
  logic [1:0]       state_d;
  logic             ready_q;
  logic             accept;
  logic             legal_a;
  logic             legal_b;
  logic             beats_a;
  logic             beats_b;
  logic             rnd_tie;
  logic             rnd_a;
  logic             rnd_b;
  logic             rnd_inv;
  logic [CNT_W-1:0] score_a_d;
  logic [CNT_W-1:0] score_b_d;
  logic             done_d;
  logic             winner_d;

  // ready_q is a pure state register; start only masks it so an aborting
  // start can never coincide with an accepted pair.
  assign in_ready = ready_q & ~start;
  assign accept   = in_valid & in_ready;

  assign legal_a = (inA == 3'b001) | (inA == 3'b010) | (inA == 3'b100);
  assign legal_b = (inB == 3'b001) | (inB == 3'b010) | (inB == 3'b100);

  // Rock beats scissors, paper beats rock, scissors beats paper.
  assign beats_a = (inA[0] & inB[2]) | (inA[1] & inB[0]) | (inA[2] & inB[1]);
  assign beats_b = (inB[0] & inA[2]) | (inB[1] & inA[0]) | (inB[2] & inA[1]);

  always_comb begin
    rnd_tie = 1'b0;
    rnd_a   = 1'b0;
    rnd_b   = 1'b0;
    rnd_inv = 1'b0;
    if (legal_a && legal_b) begin
      if (beats_a)      rnd_a   = 1'b1;
      else if (beats_b) rnd_b   = 1'b1;
      else              rnd_tie = 1'b1;
    end else begin
`ifdef RPC_INVALID_FORFEIT_EN
      if (legal_a)      rnd_a   = 1'b1;
      else if (legal_b) rnd_b   = 1'b1;
      else              rnd_inv = 1'b1;
`else
      rnd_inv = 1'b1;
`endif
    end
  end

  always_comb begin
    state_d   = state;
    score_a_d = scoreA;
    score_b_d = scoreB;
    done_d    = match_done;
    winner_d  = match_winner;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d   = S_PLAY;
          score_a_d = '0;
          score_b_d = '0;
          done_d    = 1'b0;
          winner_d  = 1'b0;
        end
      end
      S_PLAY: begin
        if (start) begin
          score_a_d = '0;
          score_b_d = '0;
          done_d    = 1'b0;
          winner_d  = 1'b0;
        end else if (accept) begin
          if (rnd_a) begin
            score_a_d = scoreA + ONE;
            if (score_a_d == WIN_CNT) begin
              state_d  = S_DONE;
              done_d   = 1'b1;
              winner_d = 1'b0;
            end
          end else if (rnd_b) begin
            score_b_d = scoreB + ONE;
            if (score_b_d == WIN_CNT) begin
              state_d  = S_DONE;
              done_d   = 1'b1;
              winner_d = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        if (start) begin
          state_d   = S_PLAY;
          score_a_d = '0;
          score_b_d = '0;
          done_d    = 1'b0;
          winner_d  = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        score_a_d = '0;
        score_b_d = '0;
        done_d    = 1'b0;
        winner_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ready_q      <= 1'b0;
      res_valid    <= 1'b0;
      res_tie      <= 1'b0;
      res_winA     <= 1'b0;
      res_winB     <= 1'b0;
      res_invalid  <= 1'b0;
      scoreA       <= '0;
      scoreB       <= '0;
      match_done   <= 1'b0;
      match_winner <= 1'b0;
    end else begin
      state        <= state_d;
      // Deciding accept drops ready on the same edge that raises match_done.
      ready_q      <= (state_d == S_PLAY);
      res_valid    <= accept;
      res_tie      <= accept & rnd_tie;
      res_winA     <= accept & rnd_a;
      res_winB     <= accept & rnd_b;
      res_invalid  <= accept & rnd_inv;
      scoreA       <= score_a_d;
      scoreB       <= score_b_d;
      match_done   <= done_d;
      match_winner <= winner_d;
    end
  end

endmodule

// File: tb/tb_rpc_match_referee.sv
module tb_rpc_match_referee;

  localparam int R     = 3;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       inA;
  logic [2:0]       inB;
  logic             res_valid;
  logic             res_tie;
  logic             res_winA;
  logic             res_winB;
  logic             res_invalid;
  logic [CNT_W-1:0] scoreA;
  logic [CNT_W-1:0] scoreB;
  logic             match_done;
  logic             match_winner;

  rpc_match_referee #(.ROUNDS_TO_WIN(R), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .inA(inA), .inB(inB), .res_valid(res_valid),
    .res_tie(res_tie), .res_winA(res_winA), .res_winB(res_winB),
    .res_invalid(res_invalid), .scoreA(scoreA), .scoreB(scoreB),
    .match_done(match_done), .match_winner(match_winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] res;   // {invalid, winB, winA, tie}
    int         sa;
    int         sb;
    bit         done;
    bit         win;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: match state as plain integers.
  bit m_play = 0;
  int m_sa   = 0;
  int m_sb   = 0;
  bit m_done = 0;
  bit m_win  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [2:0] m);
    return $countones(m) == 1;
  endfunction

  function automatic int idx(input logic [2:0] m);
    return m[0] ? 0 : (m[1] ? 1 : 2);
  endfunction

  // Returns {invalid, winB, winA, tie}.
  function automatic logic [3:0] judge(input logic [2:0] a, input logic [2:0] b);
    int d;
    if (legal(a) && legal(b)) begin
      d = (idx(a) - idx(b) + 3) % 3;
      if (d == 0) return 4'b0001;
      if (d == 1) return 4'b0010;
      return 4'b0100;
    end
`ifdef RPC_INVALID_FORFEIT_EN
    if (legal(a)) return 4'b0010;
    if (legal(b)) return 4'b0100;
`endif
    return 4'b1000;
  endfunction

  task automatic model_update(input bit s, input bit v, input logic [2:0] a,
                              input logic [2:0] b);
    exp_t e;
    if (s) begin
      m_play = 1; m_sa = 0; m_sb = 0; m_done = 0; m_win = 0;
    end else if (m_play && v) begin
      e.res = judge(a, b);
      if (e.res[1]) m_sa++;
      if (e.res[2]) m_sb++;
      if (m_sa == R) begin m_done = 1; m_win = 0; m_play = 0; end
      if (m_sb == R) begin m_done = 1; m_win = 1; m_play = 0; end
      e.sa = m_sa; e.sb = m_sb; e.done = m_done; e.win = m_win;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_state();
    chk("scoreA", int'(scoreA), m_sa);
    chk("scoreB", int'(scoreB), m_sb);
    chk("match_done", int'(match_done), int'(m_done));
    if (m_done) chk("match_winner", int'(match_winner), int'(m_win));
  endtask

  task automatic step(input bit s, input bit v, input logic [2:0] a,
                      input logic [2:0] b);
    @(negedge clk);
    check_state();
    start = s; in_valid = v; inA = a; inB = b;
    #1;
    chk("in_ready", int'(in_ready), int'(m_play && !s));
    model_update(s, v, a, b);
  endtask

  // Monitor: pops one expectation per result pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && res_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_res_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("res_bits", int'({res_invalid, res_winB, res_winA, res_tie}), int'(e.res));
        chk("res_scoreA", int'(scoreA), e.sa);
        chk("res_scoreB", int'(scoreB), e.sb);
        chk("res_done", int'(match_done), int'(e.done));
        if (e.done) chk("res_winner", int'(match_winner), int'(e.win));
      end
    end
  end

  function automatic logic [2:0] rand_move();
    logic [2:0] m;
    if ($urandom_range(0, 9) < 8) m = 3'b001 << $urandom_range(0, 2);
    else m = 3'($urandom_range(0, 7));
    return m;
  endfunction

  initial begin
    rst_n = 1'b0; start = 0; in_valid = 0; inA = 0; inB = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_outputs", int'({in_ready, res_valid, res_tie, res_winA, res_winB,
        res_invalid, match_done, match_winner}), 0);
    chk("rst_scores", int'({scoreA, scoreB}), 0);
    rst_n = 1'b1;

    // Pre-start pairs are ignored.
    step(0, 1, 3'b001, 3'b100);
    step(0, 1, 3'b001, 3'b100);

    // A wins three straight rounds, then nothing is accepted.
    step(1, 0, 3'b000, 3'b000);
    repeat (3) step(0, 1, 3'b001, 3'b100);
    repeat (3) step(0, 1, 3'b010, 3'b001);

    // Tie, B, A.
    step(1, 0, 3'b000, 3'b000);
    step(0, 1, 3'b010, 3'b010);
    step(0, 1, 3'b001, 3'b010);
    step(0, 1, 3'b100, 3'b010);
    // Illegal encodings.
    step(0, 1, 3'b011, 3'b001);
    step(0, 1, 3'b000, 3'b111);
    step(0, 0, 3'b000, 3'b000);

    // Start aborting a match at scoreA=2 with a pair present.
    step(1, 0, 3'b000, 3'b000);
    step(0, 1, 3'b001, 3'b100);
    step(0, 1, 3'b010, 3'b001);
    step(1, 1, 3'b001, 3'b100);
    step(0, 0, 3'b000, 3'b000);

    // Reset mid-match with scoreB=2.
    step(0, 1, 3'b100, 3'b001);
    step(0, 1, 3'b001, 3'b010);
    step(0, 0, 3'b000, 3'b000);
    @(negedge clk);
    check_state();
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", int'({in_ready, res_valid, res_tie, res_winA, res_winB,
        res_invalid, match_done, match_winner}), 0);
    chk("midrst_scores", int'({scoreA, scoreB}), 0);
    m_play = 0; m_sa = 0; m_sb = 0; m_done = 0; m_win = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 3'b001, 3'b100);
    step(0, 1, 3'b001, 3'b100);

    // Randomized back-to-back traffic with occasional restarts.
    step(1, 0, 3'b000, 3'b000);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
           rand_move(), rand_move());
    end
    step(0, 0, 3'b000, 3'b000);
    step(0, 0, 3'b000, 3'b000);
    @(negedge clk);
    check_state();
    chk("pending_results", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
